// File: rtl/int_logic_pipe.sv
// int_logic_pipe: pipelined bitwise logic functional unit for the scoreboard datapath.
// Evaluates one of eight bitwise ops on WIDTH-bit operands. The op is evaluated in the first
// register stage and the remaining LATENCY-1 stages are plain delay. A destination tag rides
// along with each op, and valid/ready handshakes are used on both sides.
// The whole pipe freezes while a result is waiting for the consumer.
// Optional feature: define ILP_FLAGS_EN to add the out_zero / out_par result flags, which are
// registered in step with out_res.
module int_logic_pipe #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef ILP_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_par
`endif
);

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("int_logic_pipe: LATENCY must be in 1..4");
    end
  endgenerate

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;

  // Bitwise op evaluation. All eight encodings are defined, so the default is PASS a.
  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_NOTA: r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  logic [LATENCY-1:0]            vld_p;
  logic [LATENCY-1:0][WIDTH-1:0] res_p;
  logic [LATENCY-1:0][TAG_W-1:0] tag_p;
  logic [WIDTH-1:0]              res_s1;
  logic                          stall;
  logic                          advance;

  // No bubble collapse: a held result at the output blocks every stage, including the input.
  assign stall    = vld_p[LATENCY-1] && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;
  assign res_s1   = logic_op(in_op, in_a, in_b);

  // ---- stage 1: op evaluated; stages 2..LATENCY: delay registers ----
  // Shift valid, result and tag one stage per unstalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      res_p <= '0;
      tag_p <= '0;
    end else if (advance) begin
      vld_p[0] <= in_valid;
      res_p[0] <= res_s1;
      tag_p[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        res_p[i] <= res_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

`ifdef ILP_FLAGS_EN
  logic [LATENCY-1:0] zero_p;
  logic [LATENCY-1:0] par_p;

  // ---- flags: computed beside the stage-1 result and delayed with it ----
  // Flag shift register, frozen and cleared exactly like the result path.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_p <= '0;
      par_p  <= '0;
    end else if (advance) begin
      zero_p[0] <= (res_s1 == '0);
      par_p[0]  <= ^res_s1;
      for (int i = 1; i < LATENCY; i++) begin
        zero_p[i] <= zero_p[i-1];
        par_p[i]  <= par_p[i-1];
      end
    end
  end

  assign out_zero = zero_p[LATENCY-1];
  assign out_par  = par_p[LATENCY-1];
`endif

  // ---- output stage ----
  assign out_valid = vld_p[LATENCY-1];
  assign out_res   = res_p[LATENCY-1];
  assign out_tag   = tag_p[LATENCY-1];
  assign busy      = |vld_p;

endmodule

// File: tb/tb_int_logic_pipe.sv
// tb_int_logic_pipe: randomized and directed bench for int_logic_pipe.
// The reference model evaluates each op bit by bit from a per-op truth table. Expected results
// are held in a queue until the DUT retires them. A second instance with WIDTH=32 and
// LATENCY=1 covers the narrow-latency corner.
// The flag checks are compiled in only when ILP_FLAGS_EN is defined.
module tb_int_logic_pipe;
  localparam int W = 16;
  localparam int L = 2;
  localparam int T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0, in_b = '0, out_res;
  logic [T-1:0] in_tag = '0, out_tag;
`ifdef ILP_FLAGS_EN
  logic         out_zero, out_par, v2_zero, v2_par;
`endif

  logic         v2_in_valid = 1'b0, v2_in_ready, v2_out_valid, v2_out_ready = 1'b1, v2_busy;
  logic [2:0]   v2_op = '0;
  logic [31:0]  v2_a = '0, v2_b = '0, v2_res;
  logic [3:0]   v2_tag_in = '0, v2_tag_out;

  int_logic_pipe #(.WIDTH(W), .LATENCY(L), .TAG_W(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag), .busy(busy)
`ifdef ILP_FLAGS_EN
    , .out_zero(out_zero), .out_par(out_par)
`endif
  );

  int_logic_pipe #(.WIDTH(32), .LATENCY(1), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v2_in_valid), .in_ready(v2_in_ready), .in_op(v2_op),
    .in_a(v2_a), .in_b(v2_b), .in_tag(v2_tag_in), .out_valid(v2_out_valid),
    .out_ready(v2_out_ready), .out_res(v2_res), .out_tag(v2_tag_out), .busy(v2_busy)
`ifdef ILP_FLAGS_EN
    , .out_zero(v2_zero), .out_par(v2_par)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [T-1:0] tag;
  } exp_t;
  exp_t q[$];

  logic         in_fire = 1'b0;
  int           pops = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_res = '0;
  logic [T-1:0] prev_tag = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Truth table per op, indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b1001;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // Scoreboard monitor: samples on the falling edge the handshakes of the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        in_fire    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("busy", busy, q.size() != 0);
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_res", out_res, prev_res);
          chk("stall_tag", out_tag, prev_tag);
        end
        if (out_valid) begin
          if (q.size() == 0) chk("spurious_out", out_valid, 0);
          else begin
            chk("res", out_res, q[0].res);
            chk("tag", out_tag, q[0].tag);
`ifdef ILP_FLAGS_EN
            chk("zero", out_zero, q[0].res == '0);
            chk("par", out_par, ^q[0].res);
`endif
            if (out_ready) begin
              void'(q.pop_front());
              pops++;
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_res;
        prev_tag   = out_tag;
        in_fire    = in_valid && in_ready;
        if (in_fire) q.push_back('{ref_op(in_op, in_a, in_b), in_tag});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] tag);
    int n;
    n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    do begin
      step();
      n++;
    end while (!in_fire && n < 50);
    if (!in_fire) chk("issue_timeout", in_fire, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  logic [W-1:0] t2_exp [8] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'hF00F,
                               16'h0FFF, 16'h000F, 16'h0F0F, 16'hF0F0};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   s_op;
    logic [W-1:0] s_a, s_b;
    int           pops0;
    int           n;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_v2_res", v2_res, 0);

    // Test 1: XNOR latency and tag
    out_ready = 1'b1;
    issue(3'd3, 16'h0008, 16'h0006, 4'h5);
    for (int k = 0; k < L; k++) begin
      chk("t1_lat_valid", out_valid, k == L - 1);
      if (k == L - 1) begin
        chk("t1_res", out_res, 16'hFFF1);
        chk("t1_tag", out_tag, 4'h5);
      end else step();
    end
    step();
    wait_idle();

    // Test 2: back-to-back ops 0..7
    for (int c = 0; c < 8 + L + 1; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_op = 3'(c); in_a = 16'hF0F0; in_b = 16'hFF00; in_tag = 4'(c);
      end else in_valid = 1'b0;
      if (c >= L && c < L + 8) begin
        chk("t2_valid", out_valid, 1);
        chk("t2_res", out_res, t2_exp[c-L]);
        chk("t2_tag", out_tag, 4'(c - L));
      end
      if (c == L + 8) chk("t2_done", out_valid, 0);
      step();
    end
    wait_idle();

    // Test 3: stall with the pipe full
    pops0 = pops;
    out_ready = 1'b0;
    s_op = 3'($urandom); s_a = 16'($urandom); s_b = 16'($urandom);
    issue(s_op, s_a, s_b, 4'hA);
    for (int i = 1; i < L; i++) issue(3'($urandom), 16'($urandom), 16'($urandom), 4'(i));
    in_valid = 1'b1; in_op = 3'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
    in_tag = 4'hC;
    for (int i = 0; i < 5; i++) begin
      chk("t3_in_ready", in_ready, 0);
      chk("t3_valid", out_valid, 1);
      chk("t3_res", out_res, ref_op(s_op, s_a, s_b));
      chk("t3_tag", out_tag, 4'hA);
      step();
    end
    out_ready = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!in_fire && n < 20);
    chk("t3_release_accept", in_fire, 1);
    in_valid = 1'b0;
    wait_idle();
    chk("t3_pops", pops - pops0, L + 1);

    // Test 4: reset mid-flight
    issue(3'd1, 16'h1111, 16'h2222, 4'h7);
    in_valid = 1'b1; in_op = 3'd0; in_a = 16'hFFFF; in_b = 16'hFFFF; in_tag = 4'h8;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_out_res", out_res, 0);
    chk("t4_out_tag", out_tag, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_out", out_valid, 0);
      step();
    end

`ifdef ILP_FLAGS_EN
    // Test 5: result flags
    issue(3'd2, 16'h1234, 16'h1234, 4'h1);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("t5_res0", out_res, 0);
    chk("t5_zero0", out_zero, 1);
    chk("t5_par0", out_par, 0);
    step();
    issue(3'd7, 16'h0001, 16'hFFFF, 4'h2);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("t5_res1", out_res, 16'h0001);
    chk("t5_zero1", out_zero, 0);
    chk("t5_par1", out_par, 1);
    step();
    wait_idle();
`endif

    // Test 6: WIDTH=32 LATENCY=1 instance
    chk("t6_in_ready", v2_in_ready, 1);
    v2_in_valid = 1'b1; v2_op = 3'd6; v2_a = 32'h0; v2_b = $urandom; v2_tag_in = 4'h3;
    step();
    v2_in_valid = 1'b0;
    chk("t6_valid", v2_out_valid, 1);
    chk("t6_res", v2_res, 32'hFFFF_FFFF);
    chk("t6_tag", v2_tag_out, 4'h3);
    step();
    chk("t6_valid_clr", v2_out_valid, 0);
    chk("t6_busy_clr", v2_busy, 0);

    // Randomized traffic with random backpressure
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || in_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 3'($urandom);
        in_a     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        in_b     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        in_tag   = 4'($urandom);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("rand_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
